montgomery_exp: RTL
===================

MONTGOMERY_EXP -- requirements
Module: montgomery_exp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, the width of the operand, modulus and result.
REQ-002 SHALL have parameter EXP_WIDTH, default 512, the width of the exponent.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin an exponentiation; sampled only in IDLE.
REQ-006 SHALL have port in_x, input, DATA_WIDTH bits: the base, less than in_m.
REQ-007 SHALL have port in_e, input, EXP_WIDTH bits: the exponent.
REQ-008 SHALL have port in_m, input, DATA_WIDTH bits: the odd modulus.
REQ-009 SHALL have port in_r, input, DATA_WIDTH bits: R mod M, where R = 2^DATA_WIDTH.
REQ-010 SHALL have port in_r2, input, DATA_WIDTH bits: R^2 mod M.
REQ-011 SHALL have port result, output, DATA_WIDTH bits: x^e mod M.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have mm_start (output, 1 bit), mm_a, mm_b, mm_m (outputs, DATA_WIDTH bits), mm_result (input, DATA_WIDTH bits) and mm_done (input, 1 bit) as the initiator side of the montgomery multiplier start/done port, where mm_result = a*b*R^-1 mod m.

Function
REQ-015 SHALL use the states IDLE, PRE, SQR, MUL, POST and FIN.
REQ-016 In IDLE, start=1 SHALL latch in_x, in_e, in_m, in_r and in_r2 into internal registers and move to PRE; the inputs are don't-care afterwards.
REQ-017 Each multiplication SHALL follow this handshake:
- mm_start high for exactly one cycle, on the first cycle of the operation state.
- mm_a, mm_b and mm_m held stable from mm_start until mm_done.
- mm_result captured on the mm_done cycle.
- The next mm_start issued on the following cycle.
REQ-018 PRE SHALL compute xt = MM(x, r2) and initialise the accumulator A = r; the bit index i = EXP_WIDTH-1.
REQ-019 SQR SHALL compute A = MM(A, A), then go to MUL if e[i]=1; otherwise decrement i, or go to POST when i=0.
REQ-020 MUL SHALL compute A = MM(A, xt), then decrement i, or go to POST when i=0.
REQ-021 POST SHALL compute A = MM(A, 1), then go to FIN.
REQ-022 FIN SHALL hold result = A and assert done for one cycle, then go to IDLE.
REQ-023 result SHALL hold its value until the next FIN.
REQ-024 start SHALL be ignored while busy=1; mm_done SHALL be ignored unless an operation is outstanding.
REQ-025 For e=0, result SHALL be 1 (for M>1).
REQ-026 Without the skip feature (REQ-030), the multiplication count SHALL be 2 + EXP_WIDTH + popcount(e).

Reset
REQ-027 reset=1 SHALL force IDLE on the next edge with done=0, busy=0, mm_start=0, result=0 and all internal registers cleared.
REQ-028 reset SHALL take priority over start and mm_done in the same cycle.
REQ-029 After a reset mid-operation, a late mm_done SHALL be ignored and the next start SHALL complete correctly.

Configuration
REQ-030 With MONTGOMERY_EXP_SKIP_LEADING_ZEROS_EN defined:
- i skips the leading zero bits of e.
- At the top set bit, A is loaded with xt directly, with no SQR or MUL for that bit.
- The multiplication count is bitlen(e) + popcount(e) for e>0, and 2 for e=0.
- Results are identical to the build without the macro.
REQ-031 Without MONTGOMERY_EXP_SKIP_LEADING_ZEROS_EN, all EXP_WIDTH bits SHALL be processed as in REQ-019 and REQ-020.

Structure
REQ-032 The state enum, the DATA_WIDTH and EXP_WIDTH defaults and the constant ONE (value 1, DATA_WIDTH wide) SHALL live in the shared package montgomery_pkg.
REQ-033 A sub-module montgomery_exp_scan (exponent shift register, index counter, leading-zero detect) is natural; the multiplier itself SHALL NOT be instantiated inside montgomery_exp.

Verification
The bench uses a behavioural multiplier model with programmable mm_done latency, counts mm_start pulses, and sets R and R2 per M.
REQ-034 Scenario: M=251 (0xFB), x=2, e=0x11 -> result 0x32; 7 mm_start pulses with the macro, 516 without.
REQ-035 Scenario: M=251, x=7, e=0 -> result 1; done pulse exactly one cycle; 2 pulses with the macro.
REQ-036 Scenario: M=251, x=200, e=1 -> result 200; busy falls the cycle after done.
REQ-037 Scenario: start re-asserted every cycle while busy -> exactly one done; a new start after done -> second correct result.
REQ-038 Scenario: reset asserted during the 3rd SQR, then a late mm_done -> busy=0, no done, mm_start=0; a rerun gives the correct result.
REQ-039 Scenario: model latency 1 versus 37 cycles with the 512-bit vector M=0x7e93...c393, x=0xb4d6...363b, e=0x10001 -> identical result matching the Python model.

Source files
------------

// File: rtl/montgomery_pkg.sv
// montgomery_pkg: state encoding, default widths and constants shared by montgomery_exp and its scan unit
package montgomery_pkg;
   localparam int DEF_DATA_WIDTH = 512;
   localparam int DEF_EXP_WIDTH  = 512;
   localparam logic [DEF_DATA_WIDTH-1:0] ONE = DEF_DATA_WIDTH'(1);
   typedef enum logic [2:0] {IDLE, PRE, SQR, MUL, POST, FIN} state_t;
endpackage

// File: rtl/montgomery_exp_scan.sv
// montgomery_exp_scan: exponent shift register, bit index counter and leading-zero detect.
// With MONTGOMERY_EXP_SKIP_LEADING_ZEROS_EN the scan starts just below the top set bit.
module montgomery_exp_scan
   import montgomery_pkg::*;
#(
   parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 advance,
   input  logic [EXP_WIDTH-1:0] e,
   output logic                 cur_bit,
   output logic                 last_bit,
   output logic                 no_bits,
   output logic                 top_hit
);
   localparam int CW = EXP_WIDTH > 1 ? $clog2(EXP_WIDTH) : 1;
   logic [EXP_WIDTH-1:0] sr, sr_ld;
   logic [CW-1:0] idx, idx_ld;
   logic no_ld, top_ld;
`ifdef MONTGOMERY_EXP_SKIP_LEADING_ZEROS_EN
   logic [CW-1:0] top;
   // the top set bit is consumed by loading xt, so scanning begins one bit lower
   always_comb begin
      top = '0;
      for (int k = 0; k < EXP_WIDTH; k++) top = e[k] ? CW'(k) : top;
      sr_ld = e << (EXP_WIDTH - int'(top));
      idx_ld = top - CW'(1);
      no_ld = top == '0;
      top_ld = |e;
   end
`else
   always_comb begin
      sr_ld = e;
      idx_ld = CW'(EXP_WIDTH - 1);
      no_ld = 1'b0;
      top_ld = 1'b0;
   end
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         sr <= '0;
         idx <= '0;
         no_bits <= 1'b0;
         top_hit <= 1'b0;
      end else if (load) begin
         sr <= sr_ld;
         idx <= idx_ld;
         no_bits <= no_ld;
         top_hit <= top_ld;
      end else if (advance) begin
         sr <= sr << 1;
         idx <= idx - CW'(1);
      end
   end
   assign cur_bit = sr[EXP_WIDTH-1];
   assign last_bit = idx == '0;
endmodule

// File: rtl/montgomery_exp.sv
// montgomery_exp: left-to-right modular exponentiation driving an external Montgomery multiplier.
// MONTGOMERY_EXP_SKIP_LEADING_ZEROS_EN (handled in montgomery_exp_scan) skips leading exponent zeros.
module montgomery_exp
   import montgomery_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int EXP_WIDTH  = DEF_EXP_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] in_x,
   input  logic [EXP_WIDTH-1:0]  in_e,
   input  logic [DATA_WIDTH-1:0] in_m,
   input  logic [DATA_WIDTH-1:0] in_r,
   input  logic [DATA_WIDTH-1:0] in_r2,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  done,
   output logic                  busy,
   output logic                  mm_start,
   output logic [DATA_WIDTH-1:0] mm_a,
   output logic [DATA_WIDTH-1:0] mm_b,
   output logic [DATA_WIDTH-1:0] mm_m,
   input  logic [DATA_WIDTH-1:0] mm_result,
   input  logic                  mm_done
);
   state_t state, state_nx;
   logic pend, accept, advance, load, cur_bit, last_bit, no_bits, top_hit;
   logic [DATA_WIDTH-1:0] x_reg, m_reg, r_reg, r2_reg, xt_reg, a_reg;
   assign load = state == IDLE && start;
   // a multiplier completion only counts while a request is outstanding
   assign accept = pend && mm_done;
   assign advance = accept && (state == MUL || (state == SQR && !cur_bit));
   montgomery_exp_scan #(.EXP_WIDTH(EXP_WIDTH)) u_scan (
      .clk(clk),
      .reset(reset),
      .load(load),
      .advance(advance),
      .e(in_e),
      .cur_bit(cur_bit),
      .last_bit(last_bit),
      .no_bits(no_bits),
      .top_hit(top_hit)
   );
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? PRE : IDLE;
         PRE:     state_nx = !accept ? PRE : no_bits ? POST : SQR;
         SQR:     state_nx = !accept ? SQR : cur_bit ? MUL : last_bit ? POST : SQR;
         MUL:     state_nx = !accept ? MUL : last_bit ? POST : SQR;
         POST:    state_nx = accept ? FIN : POST;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      busy = state != IDLE;
      done = state == FIN;
      mm_start = (state inside {PRE, SQR, MUL, POST}) && !pend;
      mm_a = state == PRE ? x_reg : a_reg;
      mm_b = state == PRE ? r2_reg : state == MUL ? xt_reg : state == POST ? DATA_WIDTH'(ONE) : a_reg;
      mm_m = m_reg;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= 1'b0;
         x_reg <= '0;
         m_reg <= '0;
         r_reg <= '0;
         r2_reg <= '0;
         xt_reg <= '0;
         a_reg <= '0;
         result <= '0;
      end else begin
         pend <= mm_start ? 1'b1 : accept ? 1'b0 : pend;
         if (load) begin
            x_reg <= in_x;
            m_reg <= in_m;
            r_reg <= in_r;
            r2_reg <= in_r2;
         end
         if (accept && state == PRE) xt_reg <= mm_result;
         // skipping leading zeros starts the accumulator at xt instead of R mod M
         if (accept) a_reg <= (state == PRE && !top_hit) ? r_reg : mm_result;
         if (accept && state == POST) result <= mm_result;
      end
   end
endmodule
